pipeline_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core: drives the PC enable, IF/ID enable and flush, and the control-unit NOP multiplexer select. It detects load-use hazards and taken branches, and selects operand forwarding sources for the ID stage. It sits beside the ControlUnit/Multiplexer pair and replaces the static enable_pc/enable_ifid/S drives. Saturating stall and flush counters provide performance visibility.

---
 rtl/pipeline_hazard_ctrl_if.sv | 48 ++++
 rtl/pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the hazard controller and the pipeline datapath.
// The master side (datapath/testbench) supplies the ID/EX/MEM/WB fields.
// The slave side (the controller) returns enables, the NOP select,
// forwarding selects and the event counters.
interface pipeline_hazard_ctrl_if;
    // ID-stage source operands
    logic [3:0] id_rn;
    logic [3:0] id_rm;
    logic [3:0] id_rd;
    logic       id_use_rn;
    logic       id_use_rm;
    logic       id_use_rd;
    logic       br_taken;

    // Downstream destination registers
    logic [3:0] ex_rd;
    logic [3:0] mem_rd;
    logic [3:0] wb_rd;
    logic       ex_rf_e;
    logic       mem_rf_e;
    logic       wb_rf_e;
    logic       ex_load;

    // Controller outputs
    logic       pc_e;
    logic       ifid_e;
    logic       ifid_flush;
    logic       cu_mux_s;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic [1:0] fwd_c;
    logic [7:0] stall_cnt;
    logic [7:0] flush_cnt;

    modport master (
        output id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd, br_taken,
        output ex_rd, mem_rd, wb_rd, ex_rf_e, mem_rf_e, wb_rf_e, ex_load,
        input  pc_e, ifid_e, ifid_flush, cu_mux_s,
        input  fwd_a, fwd_b, fwd_c, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd, br_taken,
        input  ex_rd, mem_rd, wb_rd, ex_rf_e, mem_rf_e, wb_rf_e, ex_load,
        output pc_e, ifid_e, ifid_flush, cu_mux_s,
        output fwd_a, fwd_b, fwd_c, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller for the five-stage core.
// Holds the pipeline with NOPs after reset, stalls one cycle on load-use,
// flushes IF/ID on taken branches, and picks per-operand forwarding sources.
// All control outputs are combinational from state and current inputs.

// Per-operand forwarding selector. One instance per ID source field.
module hazard_fwd_sel (
    input  logic [3:0] src_i,
    input  logic       use_i,
    input  logic [3:0] ex_rd_i,
    input  logic       ex_rf_e_i,
    input  logic       ex_load_i,
    input  logic [3:0] mem_rd_i,
    input  logic       mem_rf_e_i,
    input  logic [3:0] wb_rd_i,
    input  logic       wb_rf_e_i,
    output logic       ex_hit_o,
    output logic [1:0] fwd_o
);
    logic live;
    logic mem_hit;
    logic wb_hit;

    // r15 is the PC and is never a real dependency, so it never matches.
    assign live     = use_i && (src_i != 4'd15);
    assign ex_hit_o = live && ex_rf_e_i  && (src_i == ex_rd_i);
    assign mem_hit  = live && mem_rf_e_i && (src_i == mem_rd_i);
    assign wb_hit   = live && wb_rf_e_i  && (src_i == wb_rd_i);

    // Youngest producer wins; a load in EX has no data yet, so skip it.
    always_comb begin
        fwd_o = 2'b00;
        if (ex_hit_o && !ex_load_i) fwd_o = 2'b01;
        else if (mem_hit)           fwd_o = 2'b10;
        else if (wb_hit)            fwd_o = 2'b11;
    end
endmodule

module pipeline_hazard_ctrl #(
    parameter int unsigned FILL_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    pipeline_hazard_ctrl_if.slave        hz_if
);
    localparam int NUM_SRC = 3;

    localparam logic [1:0] S_FILL     = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_LU_STALL = 2'd2;

    localparam logic [3:0] FILL_LAST = 4'(FILL_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] fill_cnt_q, fill_cnt_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic [7:0] flush_cnt_q, flush_cnt_d;

    // Operand fields gathered so the selectors can be generated as an array.
    logic [NUM_SRC-1:0][3:0] src;
    logic [NUM_SRC-1:0]      src_use;
    logic [NUM_SRC-1:0]      ex_hit;
    logic [NUM_SRC-1:0][1:0] fwd_sel;

    logic lu;
    logic stall_evt;
    logic flush_evt;
    logic pc_e, ifid_e, ifid_flush, cu_mux_s;

    assign src     = {hz_if.id_rd, hz_if.id_rm, hz_if.id_rn};
    assign src_use = {hz_if.id_use_rd, hz_if.id_use_rm, hz_if.id_use_rn};

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_fwd
            hazard_fwd_sel u_sel (
                .src_i      (src[g]),
                .use_i      (src_use[g]),
                .ex_rd_i    (hz_if.ex_rd),
                .ex_rf_e_i  (hz_if.ex_rf_e),
                .ex_load_i  (hz_if.ex_load),
                .mem_rd_i   (hz_if.mem_rd),
                .mem_rf_e_i (hz_if.mem_rf_e),
                .wb_rd_i    (hz_if.wb_rd),
                .wb_rf_e_i  (hz_if.wb_rf_e),
                .ex_hit_o   (ex_hit[g]),
                .fwd_o      (fwd_sel[g])
            );
        end
    endgenerate

    // Load in EX feeding any live operand in ID.
    assign lu = hz_if.ex_load && hz_if.ex_rf_e && (|ex_hit);

    // Next-state and output decode. Default is the hold/NOP pattern.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = 4'd0;
        pc_e       = 1'b0;
        ifid_e     = 1'b0;
        ifid_flush = 1'b0;
        cu_mux_s   = 1'b1;
        stall_evt  = 1'b0;
        flush_evt  = 1'b0;
        case (state_q)
            S_FILL: begin
                fill_cnt_d = fill_cnt_q + 4'd1;
                if (fill_cnt_q == FILL_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                if (lu) begin
                    // Stall beats a same-cycle branch; it is re-seen next cycle.
                    stall_evt = 1'b1;
                    state_d   = S_LU_STALL;
                end else begin
                    pc_e       = 1'b1;
                    ifid_e     = 1'b1;
                    cu_mux_s   = 1'b0;
                    ifid_flush = hz_if.br_taken;
                    flush_evt  = hz_if.br_taken;
                end
            end
            S_LU_STALL: begin
                // Load-use masked here so a stall never lasts beyond one cycle.
                pc_e       = 1'b1;
                ifid_e     = 1'b1;
                cu_mux_s   = 1'b0;
                ifid_flush = hz_if.br_taken;
                flush_evt  = hz_if.br_taken;
                state_d    = S_RUN;
            end
            default: state_d = S_FILL;
        endcase
    end

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && stall_cnt_q != 8'hFF) stall_cnt_d = stall_cnt_q + 8'd1;
        if (flush_evt && flush_cnt_q != 8'hFF) flush_cnt_d = flush_cnt_q + 8'd1;
    end

    // State, fill counter and event counters; reset restarts a fresh fill.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FILL;
            fill_cnt_q  <= 4'd0;
            stall_cnt_q <= 8'd0;
            flush_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz_if.pc_e       = pc_e;
    assign hz_if.ifid_e     = ifid_e;
    assign hz_if.ifid_flush = ifid_flush;
    assign hz_if.cu_mux_s   = cu_mux_s;
    // Forwarding is combinational from inputs, so gate it to 00 while in reset.
    assign hz_if.fwd_a      = reset ? fwd_sel[0] : 2'b00;
    assign hz_if.fwd_b      = reset ? fwd_sel[1] : 2'b00;
    assign hz_if.fwd_c      = reset ? fwd_sel[2] : 2'b00;
    assign hz_if.stall_cnt  = stall_cnt_q;
    assign hz_if.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with an expectation queue.
// Inputs change on the falling edge; outputs are checked 2ns later.
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic reset;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(.FILL_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .hz_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_e, ifid_e, ifid_flush, cu_mux_s}
    localparam logic [3:0] C_HOLD  = 4'b0001;
    localparam logic [3:0] C_RUN   = 4'b1100;
    localparam logic [3:0] C_FLUSH = 4'b1110;

    typedef struct {
        string       tag;
        logic [25:0] v;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic expect_out(input string tag, input logic [3:0] ctl,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic [1:0] fc, input int sc, input int fcn);
        exp_t e;
        e.tag = tag;
        e.v   = {ctl, fa, fb, fc, 8'(sc), 8'(fcn)};
        q.push_back(e);
    endtask

    task automatic check_pending();
        exp_t        e;
        logic [25:0] obs;
        while (q.size() > 0) begin
            e   = q.pop_front();
            obs = {bus.pc_e, bus.ifid_e, bus.ifid_flush, bus.cu_mux_s,
                   bus.fwd_a, bus.fwd_b, bus.fwd_c, bus.stall_cnt, bus.flush_cnt};
            n_total++;
            assert (obs === e.v) n_pass++;
            else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
        end
    endtask

    // Check the current cycle, then move to the next falling edge.
    task automatic step();
        #2;
        check_pending();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.id_rn = 4'd0; bus.id_rm = 4'd0; bus.id_rd = 4'd0;
        bus.id_use_rn = 1'b0; bus.id_use_rm = 1'b0; bus.id_use_rd = 1'b0;
        bus.br_taken = 1'b0;
        bus.ex_rd = 4'd0; bus.mem_rd = 4'd0; bus.wb_rd = 4'd0;
        bus.ex_rf_e = 1'b0; bus.mem_rf_e = 1'b0; bus.wb_rf_e = 1'b0;
        bus.ex_load = 1'b0;
    endtask

    task automatic lu_rn(input logic [3:0] r);
        idle();
        bus.ex_load = 1'b1; bus.ex_rf_e = 1'b1; bus.ex_rd = r;
        bus.id_rn = r; bus.id_use_rn = 1'b1;
    endtask

    initial begin
        int s;
        reset = 1'b0;
        idle();
        // A WB match during reset must not leak onto fwd_a.
        bus.id_rn = 4'd2; bus.id_use_rn = 1'b1; bus.wb_rd = 4'd2; bus.wb_rf_e = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            expect_out("reset_hold", C_HOLD, 2'b00, 2'b00, 2'b00, 0, 0);
            step();
        end

        // Release and fill.
        reset = 1'b1;
        idle();
        expect_out("fill_0", C_HOLD, 2'b00, 2'b00, 2'b00, 0, 0); step();
        expect_out("fill_1", C_HOLD, 2'b00, 2'b00, 2'b00, 0, 0); step();
        expect_out("run_after_fill", C_RUN, 2'b00, 2'b00, 2'b00, 0, 0); step();

        // Load-use stall, then the re-presented instruction forwards from MEM.
        lu_rn(4'd3);
        expect_out("lu_stall", C_HOLD, 2'b00, 2'b00, 2'b00, 0, 0); step();
        idle();
        bus.id_rn = 4'd3; bus.id_use_rn = 1'b1; bus.mem_rd = 4'd3; bus.mem_rf_e = 1'b1;
        expect_out("lu_after_mem_fwd", C_RUN, 2'b10, 2'b00, 2'b00, 1, 0); step();
        idle();
        expect_out("run_idle", C_RUN, 2'b00, 2'b00, 2'b00, 1, 0); step();

        // Forwarding priority; rn matches but is unused.
        bus.ex_rd = 4'd5; bus.mem_rd = 4'd5; bus.wb_rd = 4'd5;
        bus.ex_rf_e = 1'b1; bus.mem_rf_e = 1'b1; bus.wb_rf_e = 1'b1;
        bus.id_rn = 4'd5; bus.id_rm = 4'd5; bus.id_use_rm = 1'b1;
        bus.id_rd = 4'd5; bus.id_use_rd = 1'b1;
        expect_out("fwd_ex", C_RUN, 2'b00, 2'b01, 2'b01, 1, 0); step();
        bus.ex_rf_e = 1'b0;
        expect_out("fwd_mem", C_RUN, 2'b00, 2'b10, 2'b10, 1, 0); step();
        bus.mem_rf_e = 1'b0;
        expect_out("fwd_wb", C_RUN, 2'b00, 2'b11, 2'b11, 1, 0); step();
        bus.id_rm = 4'd15;
        expect_out("fwd_r15", C_RUN, 2'b00, 2'b00, 2'b11, 1, 0); step();

        // Taken branch flushes for one cycle.
        idle();
        bus.br_taken = 1'b1;
        expect_out("br_flush", C_FLUSH, 2'b00, 2'b00, 2'b00, 1, 0); step();
        idle();
        expect_out("br_after", C_RUN, 2'b00, 2'b00, 2'b00, 1, 1); step();

        // Load-use with branch: stall wins; branch honoured in LU_STALL even
        // though the load-use inputs are still present.
        idle();
        bus.ex_load = 1'b1; bus.ex_rf_e = 1'b1; bus.ex_rd = 4'd7;
        bus.id_rd = 4'd7; bus.id_use_rd = 1'b1; bus.br_taken = 1'b1;
        expect_out("lu_br_stall", C_HOLD, 2'b00, 2'b00, 2'b00, 1, 1); step();
        expect_out("lustall_br", C_FLUSH, 2'b00, 2'b00, 2'b00, 2, 1); step();
        idle();
        expect_out("lu_br_after", C_RUN, 2'b00, 2'b00, 2'b00, 2, 2); step();

        // Saturation of the stall counter.
        for (int i = 0; i < 260; i++) begin
            s = (2 + i > 255) ? 255 : 2 + i;
            lu_rn(4'd4);
            expect_out("sat_stall", C_HOLD, 2'b00, 2'b00, 2'b00, s, 2); step();
            idle();
            s = (3 + i > 255) ? 255 : 3 + i;
            expect_out("sat_run", C_RUN, 2'b00, 2'b00, 2'b00, s, 2); step();
        end
        expect_out("sat_final", C_RUN, 2'b00, 2'b00, 2'b00, 255, 2); step();

        // Mid-cycle reset with a live forward.
        bus.id_rm = 4'd6; bus.id_use_rm = 1'b1; bus.wb_rd = 4'd6; bus.wb_rf_e = 1'b1;
        expect_out("pre_reset", C_RUN, 2'b00, 2'b11, 2'b00, 255, 2);
        #2;
        check_pending();
        #1 reset = 1'b0;
        #1;
        expect_out("async_reset", C_HOLD, 2'b00, 2'b00, 2'b00, 0, 0);
        check_pending();
        @(negedge clk);
        expect_out("reset_edge", C_HOLD, 2'b00, 2'b00, 2'b00, 0, 0); step();
        reset = 1'b1;
        idle();
        expect_out("refill_0", C_HOLD, 2'b00, 2'b00, 2'b00, 0, 0); step();
        expect_out("refill_1", C_HOLD, 2'b00, 2'b00, 2'b00, 0, 0); step();
        expect_out("rerun", C_RUN, 2'b00, 2'b00, 2'b00, 0, 0); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
